// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Step counter width: must hold 0..4*DIGITS.
  function automatic int cnt_width(input int digits);
    return $clog2(DIGIT_W * digits + 1);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_bcd_digit_adjust.sv
// One BCD digit correction for reverse double dabble: subtract 3 when >= 8.
module bcd_digit_adjust
  import bcd2bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = (d_in >= 4'd8) ? d_in - 4'd3 : d_in;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one shift/adjust step per clock.
// Optional invalid-digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_binary_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic [BIN_W-1:0]          binary,
  output logic                      ovf,
  output logic                      err
);

  localparam int NB = DIGIT_W * DIGITS;
  localparam int WW = 2 * NB;
  localparam int CW = cnt_width(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_t            state_q, state_d;
  logic [WW-1:0]     work_q, work_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]  binary_q, binary_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [WW-1:0]     shifted;
  logic [WW-1:0]     stepped;
  logic [NB-1:0]     adj;
  logic [NB-1:0]     value;

  assign shifted = work_q >> 1;

  // Digit fields live in the upper half of the work register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (shifted[NB + DIGIT_W*g +: DIGIT_W]),
      .d_out (adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign stepped = {adj, shifted[NB-1:0]};
  assign value   = stepped[NB-1:0];

`ifdef BCD2BIN_CHECK_EN
  logic invalid;
  always_comb begin
    invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[NB + DIGIT_W*i +: DIGIT_W] > 4'd9) invalid = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          work_d  = {bcd_in, {NB{1'b0}}};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = CONV;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CONV: begin
`ifdef BCD2BIN_CHECK_EN
        // The loaded digits are still unshifted on the first CONV cycle.
        if (cnt_q == '0 && invalid) begin
          err_d    = 1'b1;
          binary_d = '0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else
`endif
        begin
          work_d = stepped;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            if ((value >> BIN_W) != '0) begin
              ovf_d    = 1'b1;
              binary_d = '1;
            end else begin
              ovf_d    = 1'b0;
              binary_d = value[BIN_W-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == CONV);
  assign done   = (state_q == DONE);
  assign binary = binary_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule
